// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch PC controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        REDIR = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    // PC value the PC register comes out of reset with
    localparam logic [15:0] RESET_PC = 16'h0000;
    // Byte increment per sequential 16-bit instruction
    localparam logic [15:0] PC_INC   = 16'd2;
    // Opcode field value that stops fetch
    localparam logic [3:0]  OPC_HLT  = 4'hF;

    // True when the opcode field of a fetched word matches the halt opcode
    function automatic logic is_hlt(input logic [15:0] word, input logic [3:0] opc);
        return word[15:12] == opc;
    endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
// Latency: count reflects an inc one cycle after it is sampled.
// Backpressure: none; inc is sampled every cycle.
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] cnt
);

    // Count up on inc, hold once the maximum is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'h0000;
        end else if (inc && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Next-PC selection and instruction-memory read sequencing between the PC register and decode.
// Latency: pc_next is combinational from pc and inputs; an accepted word appears on instr one cycle later.
// Backpressure: stall holds pc and the presented instr; an unaccepted read keeps imem_addr stable. FETCH_PERF_CNT_EN adds perf counters.
module fetch_pc_ctrl #(
    parameter logic [15:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter logic [15:0] PC_INC   = fetch_pkg::PC_INC,
    parameter logic [3:0]  OPC_HLT  = fetch_pkg::OPC_HLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    output logic [15:0] pc_next,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic [15:0] instr,
    output logic        instr_vld,
    output logic        halted,
    output logic [15:0] fetch_cnt,
    output logic [15:0] bubble_cnt
);
    import fetch_pkg::*;

    fetch_state_t state;
    // Destination of the most recent redirect seen while a squashed read was still outstanding
    logic [15:0]  redir_pc;
    logic         accept;
    logic         data_hlt;

    // A read is outstanding whenever we are fetching or draining a squashed read
    assign imem_req  = (state == FETCH) || (state == REDIR);
    // The PC register only moves when the read at pc completes, so pc is a stable address
    assign imem_addr = pc;
    // Words returned while draining a squashed read are dropped, so only FETCH can accept
    assign accept    = (state == FETCH) && imem_rdy && !stall && !br_taken;
    assign data_hlt  = is_hlt(imem_data, OPC_HLT);

    // Next PC: hold unless a word is accepted or a redirect can take effect this cycle
    always_comb begin
        pc_next = pc;
        case (state)
            FETCH: begin
                if (br_taken) begin
                    // Without data in hand the old read must drain first; pc stays put
                    if (imem_rdy) begin
                        pc_next = br_target;
                    end
                end else if (accept && !data_hlt) begin
                    pc_next = pc + PC_INC;
                end
            end
            REDIR: begin
                if (imem_rdy) begin
                    pc_next = br_taken ? br_target : redir_pc;
                end
            end
            HALT: begin
                if (br_taken) begin
                    pc_next = br_target;
                end
            end
            default: begin
                pc_next = pc;
            end
        endcase
    end

    // Fetch sequencer with registered instr/instr_vld/halted and pending redirect target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            instr     <= 16'h0000;
            instr_vld <= 1'b0;
            halted    <= 1'b0;
            redir_pc  <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    // One settling cycle so the PC register's reset value is seen before the first read
                    state <= FETCH;
                end
                FETCH: begin
                    if (br_taken) begin
                        instr_vld <= 1'b0;
                        if (!imem_rdy) begin
                            redir_pc <= br_target;
                            state    <= REDIR;
                        end
                    end else if (!imem_rdy) begin
                        // A stalled decode still owns the current instr, so keep it valid
                        if (!stall) begin
                            instr_vld <= 1'b0;
                        end
                    end else if (!stall) begin
                        instr     <= imem_data;
                        instr_vld <= 1'b1;
                        if (data_hlt) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                    end
                end
                REDIR: begin
                    instr_vld <= 1'b0;
                    if (imem_rdy) begin
                        state <= FETCH;
                    end else if (br_taken) begin
                        redir_pc <= br_target;
                    end
                end
                HALT: begin
                    if (br_taken) begin
                        // The HLT was on a mispredicted path; resume at the target
                        halted    <= 1'b0;
                        instr_vld <= 1'b0;
                        state     <= FETCH;
                    end else if (!stall) begin
                        instr_vld <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    sat_cnt16 u_fetch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .cnt   (fetch_cnt)
    );

    sat_cnt16 u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (imem_req && !accept),
        .cnt   (bubble_cnt)
    );
`else
    assign fetch_cnt  = 16'h0000;
    assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed vector table, reset corner cases, randomized run against a flag-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic [15:0] instr;
    logic        instr_vld;
    logic        halted;
    logic [15:0] fetch_cnt;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // The PC register this block drives: loads pc_next every cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 16'h0000;
        else        pc <= pc_next;
    end

    fetch_pc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .pc_next    (pc_next),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdy   (imem_rdy),
        .imem_data  (imem_data),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .instr      (instr),
        .instr_vld  (instr_vld),
        .halted     (halted),
        .fetch_cnt  (fetch_cnt),
        .bubble_cnt (bubble_cnt)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic b,
                         input logic [15:0] d, input logic [15:0] t);
        @(negedge clk);
        imem_rdy  = r;
        stall     = s;
        br_taken  = b;
        imem_data = d;
        br_target = t;
        #1;
    endtask

    typedef struct {
        logic        rdy;
        logic        stall;
        logic        br;
        logic [15:0] data;
        logic [15:0] tgt;
        logic [15:0] e_pcn;
        logic        e_req;
        logic [15:0] e_instr;
        logic        e_vld;
        logic        e_halt;
    } vec_t;

    function automatic vec_t v(input logic rdy, input logic s, input logic br,
                               input logic [15:0] data, input logic [15:0] tgt,
                               input logic [15:0] e_pcn, input logic e_req,
                               input logic [15:0] e_instr, input logic e_vld, input logic e_halt);
        vec_t r;
        r.rdy = rdy; r.stall = s; r.br = br; r.data = data; r.tgt = tgt;
        r.e_pcn = e_pcn; r.e_req = e_req; r.e_instr = e_instr; r.e_vld = e_vld; r.e_halt = e_halt;
        return r;
    endfunction

    // Instruction memory contents for the random run
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] m;
        m = a * 16'h9E37;
        return m ^ 16'h5A5A;
    endfunction

    vec_t tbl[$];

    // Reference model state: progress flags rather than a state code
    bit          m_started, m_halt, m_squash, m_vld;
    logic [15:0] m_sq_pc, m_instr;
    int unsigned m_fc, m_bc;

    initial begin
        //               rdy st br data      tgt       e_pcn    req e_instr  vld halt
        tbl.push_back(v(1, 0, 0, 16'h1234, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0)); // IDLE
        tbl.push_back(v(1, 0, 0, 16'h1234, 16'h0000, 16'h0002, 1, 16'h1234, 1, 0)); // pc 0
        tbl.push_back(v(1, 0, 0, 16'h5678, 16'h0000, 16'h0004, 1, 16'h5678, 1, 0)); // pc 2
        tbl.push_back(v(1, 0, 1, 16'h9999, 16'h000E, 16'h000E, 1, 16'h5678, 0, 0)); // redirect with data
        tbl.push_back(v(1, 0, 0, 16'h1111, 16'h0000, 16'h0010, 1, 16'h1111, 1, 0)); // pc E
        tbl.push_back(v(1, 1, 0, 16'h2222, 16'h0000, 16'h0010, 1, 16'h1111, 1, 0)); // stall x3 at 10
        tbl.push_back(v(1, 1, 0, 16'h2222, 16'h0000, 16'h0010, 1, 16'h1111, 1, 0));
        tbl.push_back(v(1, 1, 0, 16'h2222, 16'h0000, 16'h0010, 1, 16'h1111, 1, 0));
        tbl.push_back(v(1, 0, 0, 16'h2222, 16'h0000, 16'h0012, 1, 16'h2222, 1, 0)); // release
        tbl.push_back(v(1, 0, 1, 16'h7777, 16'h0020, 16'h0020, 1, 16'h2222, 0, 0));
        tbl.push_back(v(0, 0, 1, 16'h0000, 16'h0080, 16'h0020, 1, 16'h2222, 0, 0)); // pc 20 -> REDIR
        tbl.push_back(v(0, 1, 0, 16'h0000, 16'h0000, 16'h0020, 1, 16'h2222, 0, 0)); // stall ignored
        tbl.push_back(v(1, 1, 0, 16'hDEAD, 16'h0000, 16'h0080, 1, 16'h2222, 0, 0)); // late word dropped
        tbl.push_back(v(1, 0, 0, 16'h3333, 16'h0000, 16'h0082, 1, 16'h3333, 1, 0)); // pc 80
        tbl.push_back(v(0, 0, 1, 16'h0000, 16'h0040, 16'h0082, 1, 16'h3333, 0, 0)); // REDIR to 40
        tbl.push_back(v(0, 0, 1, 16'h0000, 16'h0060, 16'h0082, 1, 16'h3333, 0, 0)); // overwritten by 60
        tbl.push_back(v(1, 0, 0, 16'hBEEF, 16'h0000, 16'h0060, 1, 16'h3333, 0, 0));
        tbl.push_back(v(1, 0, 0, 16'h4444, 16'h0000, 16'h0062, 1, 16'h4444, 1, 0)); // pc 60
        tbl.push_back(v(0, 1, 0, 16'h0000, 16'h0000, 16'h0062, 1, 16'h4444, 1, 0)); // no data, stall holds vld
        tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 16'h0062, 1, 16'h4444, 0, 0)); // no data clears vld
        tbl.push_back(v(1, 0, 1, 16'h8888, 16'h0030, 16'h0030, 1, 16'h4444, 0, 0));
        tbl.push_back(v(1, 0, 0, 16'hF000, 16'h0000, 16'h0030, 1, 16'hF000, 1, 1)); // HLT at 30
        tbl.push_back(v(1, 1, 0, 16'hF000, 16'h0000, 16'h0030, 0, 16'hF000, 1, 1)); // decode stalled on HLT
        tbl.push_back(v(1, 0, 0, 16'hF000, 16'h0000, 16'h0030, 0, 16'hF000, 0, 1)); // HLT consumed
        tbl.push_back(v(1, 0, 1, 16'hF000, 16'h0100, 16'h0100, 0, 16'hF000, 0, 0)); // squash HLT
        tbl.push_back(v(1, 0, 0, 16'h5555, 16'h0000, 16'h0102, 1, 16'h5555, 1, 0)); // pc 100
        tbl.push_back(v(1, 0, 1, 16'hAAAA, 16'hFFFE, 16'hFFFE, 1, 16'h5555, 0, 0));
        tbl.push_back(v(1, 0, 0, 16'h6666, 16'h0000, 16'h0000, 1, 16'h6666, 1, 0)); // wrap
        tbl.push_back(v(1, 0, 0, 16'hF000, 16'h0000, 16'h0000, 1, 16'hF000, 1, 1)); // HLT at 0

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset instr", instr, 16'h0000);
        chk("reset instr_vld", {15'd0, instr_vld}, 16'd0);
        chk("reset halted", {15'd0, halted}, 16'd0);
        chk("reset imem_req", {15'd0, imem_req}, 16'd0);
        chk("reset fetch_cnt", fetch_cnt, 16'h0000);
        chk("reset bubble_cnt", bubble_cnt, 16'h0000);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed table
        foreach (tbl[i]) begin
            drive(tbl[i].rdy, tbl[i].stall, tbl[i].br, tbl[i].data, tbl[i].tgt);
            chk($sformatf("row%0d pc_next", i), pc_next, tbl[i].e_pcn);
            chk($sformatf("row%0d imem_req", i), {15'd0, imem_req}, {15'd0, tbl[i].e_req});
            chk($sformatf("row%0d imem_addr", i), imem_addr, pc);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d instr", i), instr, tbl[i].e_instr);
            chk($sformatf("row%0d instr_vld", i), {15'd0, instr_vld}, {15'd0, tbl[i].e_vld});
            chk($sformatf("row%0d halted", i), {15'd0, halted}, {15'd0, tbl[i].e_halt});
        end

        // Reset while halted clears halted/instr_vld without waiting for a clock
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst halt halted", {15'd0, halted}, 16'd0);
        chk("rst halt instr_vld", {15'd0, instr_vld}, 16'd0);
        chk("rst halt instr", instr, 16'h0000);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset with a read outstanding and decode stalled on a valid instr
        drive(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
        @(posedge clk);
        drive(1'b1, 1'b0, 1'b0, 16'hABCD, 16'h0000);
        @(posedge clk);
        #1;
        chk("midread instr", instr, 16'hABCD);
        chk("midread instr_vld", {15'd0, instr_vld}, 16'd1);
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        chk("midread imem_req", {15'd0, imem_req}, 16'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midread rst instr_vld", {15'd0, instr_vld}, 16'd0);
        chk("midread rst instr", instr, 16'h0000);
        chk("midread rst imem_req", {15'd0, imem_req}, 16'd0);
        chk("midread rst pc_next", pc_next, 16'h0000);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Randomized run against the reference model
        m_started = 0; m_halt = 0; m_squash = 0; m_vld = 0;
        m_sq_pc = 16'h0000; m_instr = 16'h0000; m_fc = 0; m_bc = 0;
        for (int n = 0; n < 4000; n++) begin
            logic        r, s, b, req_e, acc;
            logic [15:0] t, d, pcn_e;
            r = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            t = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 7) == 0) t = 16'hFFFE;
            @(negedge clk);
            d = mem_word(pc);
            imem_rdy = r; stall = s; br_taken = b; br_target = t; imem_data = d;
            #1;
            req_e = m_started && !m_halt;
            acc   = 1'b0;
            pcn_e = pc;
            if (!m_started) begin
                m_started = 1;
            end else if (m_halt) begin
                if (b) begin
                    pcn_e = t; m_halt = 0; m_vld = 0;
                end else if (!s) begin
                    m_vld = 0;
                end
            end else if (m_squash) begin
                m_vld = 0;
                if (r) begin
                    pcn_e = b ? t : m_sq_pc;
                    m_squash = 0;
                end else if (b) begin
                    m_sq_pc = t;
                end
            end else if (b) begin
                m_vld = 0;
                if (r) pcn_e = t;
                else begin m_squash = 1; m_sq_pc = t; end
            end else if (!r) begin
                if (!s) m_vld = 0;
            end else if (!s) begin
                acc = 1'b1;
                m_instr = d;
                m_vld = 1;
                if (d[15:12] == 4'hF) m_halt = 1;
                else pcn_e = pc + 16'd2;
            end
            if (acc && m_fc < 65535) m_fc++;
            if (req_e && !acc && m_bc < 65535) m_bc++;
            chk($sformatf("rnd%0d pc_next", n), pc_next, pcn_e);
            chk($sformatf("rnd%0d imem_req", n), {15'd0, imem_req}, {15'd0, req_e});
            chk($sformatf("rnd%0d imem_addr", n), imem_addr, pc);
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d instr", n), instr, m_instr);
            chk($sformatf("rnd%0d instr_vld", n), {15'd0, instr_vld}, {15'd0, m_vld});
            chk($sformatf("rnd%0d halted", n), {15'd0, halted}, {15'd0, m_halt});
`ifdef FETCH_PERF_CNT_EN
            chk($sformatf("rnd%0d fetch_cnt", n), fetch_cnt, 16'(m_fc));
            chk($sformatf("rnd%0d bubble_cnt", n), bubble_cnt, 16'(m_bc));
`else
            chk($sformatf("rnd%0d fetch_cnt", n), fetch_cnt, 16'h0000);
            chk($sformatf("rnd%0d bubble_cnt", n), bubble_cnt, 16'h0000);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
